// File: rtl/lsu1_dreq.sv
// lsu1_dreq: LSU stage-1 data-request engine. Issues one data-bus transaction
// per memory instruction, stalls the pipeline until it completes, and presents
// the aligned/extended load result to LSU2.
module lsu1_dreq (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_flush,
  input  logic        lsu1_stall_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_alu_res_i,
  input  logic [31:0] ex_rt_data_i,
  input  logic        ex_mem_en_i,
  input  logic        ex_mem_wr_i,
  input  logic [1:0]  ex_mem_size_i,
  input  logic        ex_mem_unsigned_i,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        lsu1_stall_req_o,
  output logic [31:0] lsu1_rdata_o,
  output logic        lsu1_rdata_valid_o,
  output logic        lsu1_addr_err_o,
  output logic [31:0] lsu1_bad_vaddr_o
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, CANCEL} state_t;

  state_t      state_reg, state_next;
  logic        misaligned;
  logic        issue;
  logic        stall_raw;
  logic [1:0]  addr_lo_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic        wr_reg;
  logic [31:0] rdata_reg;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_val;
  logic        unused_pc;

  // The PC travels with the instruction but this stage has no use for it.
  assign unused_pc = ^ex_pc_i;

  // Alignment check; size 3 behaves like a word access.
  always_comb begin
    misaligned = 1'b0;
    if (ex_mem_en_i) begin
      case (ex_mem_size_i)
        2'd0:    misaligned = 1'b0;
        2'd1:    misaligned = ex_alu_res_i[0];
        default: misaligned = (ex_alu_res_i[1:0] != 2'b00);
      endcase
    end
  end

  assign lsu1_addr_err_o  = misaligned;
  assign lsu1_bad_vaddr_o = ex_alu_res_i;

  // A request is presented from IDLE for a legal access, or held in ADDR;
  // a flush withdraws it in the same cycle.
  assign issue = ((state_reg == IDLE && ex_mem_en_i && !misaligned) ||
                  state_reg == ADDR) && !exception_flush;

  // Outputs are forced low while reset is held so nothing leaks during reset.
  assign data_req         = issue && !rst;
  assign lsu1_stall_req_o = stall_raw && !rst;

  // Request fields come straight from the held EX->LSU1 register, so they stay
  // stable for as long as the stall keeps that register frozen.
  assign data_addr = ex_alu_res_i;
  assign data_size = ex_mem_size_i;
  assign data_wr   = ex_mem_wr_i;

  // Store data replicated into every lane the access could hit.
  always_comb begin
    case (ex_mem_size_i)
      2'd0:    data_wdata = {4{ex_rt_data_i[7:0]}};
      2'd1:    data_wdata = {2{ex_rt_data_i[15:0]}};
      default: data_wdata = ex_rt_data_i;
    endcase
  end

  // Next-state logic for the request/response handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (issue) state_next = data_addr_ok ? DATA : ADDR;
      end
      ADDR: begin
        if (exception_flush)   state_next = IDLE;
        else if (data_addr_ok) state_next = DATA;
      end
      DATA: begin
        if (data_data_ok)         state_next = exception_flush ? IDLE : DONE;
        else if (exception_flush) state_next = CANCEL;
      end
      DONE: begin
        if (exception_flush)   state_next = IDLE;
        else if (!lsu1_stall_i) state_next = IDLE;
      end
      CANCEL: begin
        if (data_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall request: held while a transaction is open, released in DONE.
  always_comb begin
    stall_raw = 1'b0;
    case (state_reg)
      IDLE:       stall_raw = issue;
      ADDR, DATA: stall_raw = 1'b1;
      CANCEL:     stall_raw = ex_mem_en_i;
      default:    stall_raw = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Capture access attributes whenever a request is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_lo_reg  <= 2'b00;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      wr_reg       <= 1'b0;
    end else if (issue) begin
      addr_lo_reg  <= ex_alu_res_i[1:0];
      size_reg     <= ex_mem_size_i;
      unsigned_reg <= ex_mem_unsigned_i;
      wr_reg       <= ex_mem_wr_i;
    end
  end

  // Capture the read word on a live response; flushed responses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_reg <= 32'h0;
    else if (state_reg == DATA && data_data_ok && !exception_flush)
      rdata_reg <= data_rdata;
  end

  // Lane selection and sign/zero extension of the captured word.
  always_comb begin
    case (addr_lo_reg)
      2'd0:    byte_val = rdata_reg[7:0];
      2'd1:    byte_val = rdata_reg[15:8];
      2'd2:    byte_val = rdata_reg[23:16];
      default: byte_val = rdata_reg[31:24];
    endcase
    half_val = addr_lo_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
    case (size_reg)
      2'd0:    load_val = {{24{byte_val[7] & ~unsigned_reg}}, byte_val};
      2'd1:    load_val = {{16{half_val[15] & ~unsigned_reg}}, half_val};
      default: load_val = rdata_reg;
    endcase
  end

  assign lsu1_rdata_o       = wr_reg ? 32'h0 : load_val;
  assign lsu1_rdata_valid_o = (state_reg == DONE) && !exception_flush;

endmodule

// File: tb/tb_lsu1_dreq.sv
// tb_lsu1_dreq: drives lsu1_dreq as pipeline and bus, checking each cycle
// against expectations computed from the access rules.
module tb_lsu1_dreq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exception_flush = 1'b0;
  logic        lsu1_stall_i = 1'b0;
  logic [31:0] ex_pc_i = 32'h0;
  logic [31:0] ex_alu_res_i = 32'h0;
  logic [31:0] ex_rt_data_i = 32'h0;
  logic        ex_mem_en_i = 1'b0;
  logic        ex_mem_wr_i = 1'b0;
  logic [1:0]  ex_mem_size_i = 2'd0;
  logic        ex_mem_unsigned_i = 1'b0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'h0;
  logic        lsu1_stall_req_o;
  logic [31:0] lsu1_rdata_o;
  logic        lsu1_rdata_valid_o;
  logic        lsu1_addr_err_o;
  logic [31:0] lsu1_bad_vaddr_o;

  int errors = 0;
  int checks = 0;
  int op_num = 0;

  lsu1_dreq dut (
    .clk(clk), .rst(rst), .exception_flush(exception_flush),
    .lsu1_stall_i(lsu1_stall_i), .ex_pc_i(ex_pc_i), .ex_alu_res_i(ex_alu_res_i),
    .ex_rt_data_i(ex_rt_data_i), .ex_mem_en_i(ex_mem_en_i), .ex_mem_wr_i(ex_mem_wr_i),
    .ex_mem_size_i(ex_mem_size_i), .ex_mem_unsigned_i(ex_mem_unsigned_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .lsu1_stall_req_o(lsu1_stall_req_o), .lsu1_rdata_o(lsu1_rdata_o),
    .lsu1_rdata_valid_o(lsu1_rdata_valid_o), .lsu1_addr_err_o(lsu1_addr_err_o),
    .lsu1_bad_vaddr_o(lsu1_bad_vaddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: access rules expressed arithmetically.
  function automatic logic ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] rt);
    if (size == 2'd0) return (rt & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (rt & 32'hFFFF) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] ref_result(input logic wr, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    if (wr) return 32'h0;
    if (size == 2'd0) begin
      sh = 8 * int'(addr % 4);
      v = (rd >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
      return v;
    end
    if (size == 2'd1) begin
      sh = 16 * int'((addr % 4) / 2);
      v = (rd >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
      return v;
    end
    return rd;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rt);
    ex_mem_en_i = 1'b1;
    ex_mem_wr_i = wr;
    ex_mem_size_i = size;
    ex_mem_unsigned_i = uns;
    ex_alu_res_i = addr;
    ex_rt_data_i = rt;
    ex_pc_i = $urandom;
  endtask

  // One complete memory op: aw cycles of addr_ok wait, dw cycles of data_ok
  // wait, st cycles of downstream stall while holding the result.
  task automatic run_op(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rd, input int aw, input int dw, input int st);
    logic        mis;
    logic [31:0] exp_wd, exp_res;
    mis = ref_misaligned(size, addr);
    exp_wd = ref_wdata(size, rt);
    exp_res = ref_result(wr, size, uns, addr, rd);
    present(wr, size, uns, addr, rt);
    exception_flush = 1'b0;
    lsu1_stall_i = 1'b0;
    data_data_ok = 1'b0;
    op_num++;
    if (mis) begin
      data_addr_ok = 1'b0;
      @(negedge clk);
      chk("misalign_err", {31'h0, lsu1_addr_err_o}, 32'h1);
      chk("misalign_badvaddr", lsu1_bad_vaddr_o, addr);
      chk("misalign_req", {31'h0, data_req}, 32'h0);
      chk("misalign_stall", {31'h0, lsu1_stall_req_o}, 32'h0);
      next_cycle();
      $display("op %0d: misaligned wr=%0d size=%0d addr=%h", op_num, wr, size, addr);
      return;
    end
    for (int c = 0; c <= aw; c++) begin
      data_addr_ok = (c == aw);
      data_rdata = $urandom;
      @(negedge clk);
      chk("req_valid", {31'h0, data_req}, 32'h1);
      chk("req_stall", {31'h0, lsu1_stall_req_o}, 32'h1);
      chk("req_err", {31'h0, lsu1_addr_err_o}, 32'h0);
      chk("req_addr", data_addr, addr);
      chk("req_wdata", data_wdata, exp_wd);
      chk("req_size", {30'h0, data_size}, {30'h0, size});
      chk("req_wr", {31'h0, data_wr}, {31'h0, wr});
      chk("req_rvalid", {31'h0, lsu1_rdata_valid_o}, 32'h0);
      next_cycle();
    end
    data_addr_ok = 1'b0;
    for (int d = 0; d <= dw; d++) begin
      data_data_ok = (d == dw);
      data_rdata = (d == dw) ? rd : $urandom;
      @(negedge clk);
      chk("data_req", {31'h0, data_req}, 32'h0);
      chk("data_stall", {31'h0, lsu1_stall_req_o}, 32'h1);
      chk("data_rvalid", {31'h0, lsu1_rdata_valid_o}, 32'h0);
      next_cycle();
    end
    data_data_ok = 1'b0;
    for (int s = 0; s <= st; s++) begin
      lsu1_stall_i = (s < st);
      data_rdata = $urandom;
      @(negedge clk);
      chk("done_rvalid", {31'h0, lsu1_rdata_valid_o}, 32'h1);
      chk("done_rdata", lsu1_rdata_o, exp_res);
      chk("done_stall", {31'h0, lsu1_stall_req_o}, 32'h0);
      chk("done_req", {31'h0, data_req}, 32'h0);
      next_cycle();
    end
    lsu1_stall_i = 1'b0;
    $display("op %0d: wr=%0d size=%0d uns=%0d addr=%h rdata=%h result=%h aw=%0d dw=%0d st=%0d",
             op_num, wr, size, uns, addr, rd, exp_res, aw, dw, st);
  endtask

  task automatic idle_op(input logic [31:0] addr);
    ex_mem_en_i = 1'b0;
    ex_alu_res_i = addr;
    ex_mem_size_i = 2'($urandom_range(0, 3));
    data_addr_ok = 1'($urandom_range(0, 1));
    data_data_ok = 1'b0;
    op_num++;
    @(negedge clk);
    chk("idle_req", {31'h0, data_req}, 32'h0);
    chk("idle_stall", {31'h0, lsu1_stall_req_o}, 32'h0);
    chk("idle_rvalid", {31'h0, lsu1_rdata_valid_o}, 32'h0);
    chk("idle_err", {31'h0, lsu1_addr_err_o}, 32'h0);
    next_cycle();
    data_addr_ok = 1'b0;
    $display("op %0d: bubble addr=%h", op_num, addr);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    // Reset held with a legal load present: nothing may be requested.
    present(1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0);
    #3;
    chk("rst_req", {31'h0, data_req}, 32'h0);
    chk("rst_stall", {31'h0, lsu1_stall_req_o}, 32'h0);
    chk("rst_rvalid", {31'h0, lsu1_rdata_valid_o}, 32'h0);
    chk("rst_rdata", lsu1_rdata_o, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_mem_en_i = 1'b0;
    $display("reset released");

    // Directed cases.
    run_op(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 32'h1234_5678, 0, 0, 0);
    run_op(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h8000_0000, 0, 0, 0);
    run_op(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 32'h8000_0000, 0, 0, 0);
    run_op(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'hABCD_0000, 0, 0, 0);
    run_op(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_BEEF, 32'h5555_5555, 0, 0, 0);
    run_op(1'b0, 2'd2, 1'b0, 32'h8000_0006, 32'h0, 32'h0, 0, 0, 0);

    // Flush in DATA, response 3 cycles later, next load pending.
    present(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("cancel_req0", {31'h0, data_req}, 32'h1);
    next_cycle();
    data_addr_ok = 1'b0;
    exception_flush = 1'b1;
    @(negedge clk);
    chk("cancel_flush_req", {31'h0, data_req}, 32'h0);
    chk("cancel_flush_stall", {31'h0, lsu1_stall_req_o}, 32'h1);
    chk("cancel_flush_rvalid", {31'h0, lsu1_rdata_valid_o}, 32'h0);
    next_cycle();
    exception_flush = 1'b0;
    present(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 3; i++) begin
      data_data_ok = (i == 2);
      data_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("cancel_drain_req", {31'h0, data_req}, 32'h0);
      chk("cancel_drain_stall", {31'h0, lsu1_stall_req_o}, 32'h1);
      chk("cancel_drain_rvalid", {31'h0, lsu1_rdata_valid_o}, 32'h0);
      next_cycle();
    end
    data_data_ok = 1'b0;
    $display("cancel drain complete");
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 0, 1, 0);

    // Flush coinciding with the response in DATA: response discarded.
    present(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0);
    data_addr_ok = 1'b1;
    next_cycle();
    data_addr_ok = 1'b0;
    exception_flush = 1'b1;
    data_data_ok = 1'b1;
    @(negedge clk);
    chk("flushok_stall", {31'h0, lsu1_stall_req_o}, 32'h1);
    chk("flushok_rvalid", {31'h0, lsu1_rdata_valid_o}, 32'h0);
    next_cycle();
    exception_flush = 1'b0;
    data_data_ok = 1'b0;
    idle_op(32'h0000_0304);

    // Flush with addr_ok in IDLE, then flush in ADDR: no transaction starts.
    present(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0);
    exception_flush = 1'b1;
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("idleflush_req", {31'h0, data_req}, 32'h0);
    chk("idleflush_stall", {31'h0, lsu1_stall_req_o}, 32'h0);
    next_cycle();
    exception_flush = 1'b0;
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("addr_wait_req", {31'h0, data_req}, 32'h1);
    next_cycle();
    exception_flush = 1'b1;
    @(negedge clk);
    chk("addrflush_req", {31'h0, data_req}, 32'h0);
    chk("addrflush_stall", {31'h0, lsu1_stall_req_o}, 32'h1);
    next_cycle();
    exception_flush = 1'b0;
    $display("flush during request phase complete");
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 32'h7777_1111, 0, 0, 0);

    // Held result under downstream stall, then reset in the middle of ADDR.
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 1, 2, 4);
    present(1'b0, 2'd2, 1'b0, 32'h0000_0600, 32'h0);
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", {31'h0, data_req}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("pre_rst_stall", {31'h0, lsu1_stall_req_o}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'h0, data_req}, 32'h0);
    chk("midrst_stall", {31'h0, lsu1_stall_req_o}, 32'h0);
    chk("midrst_rvalid", {31'h0, lsu1_rdata_valid_o}, 32'h0);
    chk("midrst_rdata", lsu1_rdata_o, 32'h0);
    next_cycle();
    rst = 1'b0;
    ex_mem_en_i = 1'b0;
    data_data_ok = 1'b1;
    @(negedge clk);
    chk("late_ok_rvalid", {31'h0, lsu1_rdata_valid_o}, 32'h0);
    next_cycle();
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("late_ok_rvalid2", {31'h0, lsu1_rdata_valid_o}, 32'h0);
    chk("late_ok_stall", {31'h0, lsu1_stall_req_o}, 32'h0);
    next_cycle();
    $display("mid-transaction reset complete");

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_op($urandom);
      end else begin
        sz = 2'($urandom_range(0, 3));
        a = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'd1) a[0] = 1'b0;
          else if (sz != 2'd0) a[1:0] = 2'b00;
        end
        run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
               $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
